// File: rtl/rs_dispatch_pkg.sv
// rs_dispatch_pkg: shared sizes, op-class encodings, the reservation-station
// operand record and the operand-capture helper used at dispatch time.
package rs_dispatch_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_SIZE  = 6;
    localparam int UNIT_SIZE = 8;
    localparam int NUM_ENT   = 8;
    localparam int ENT_IDX_W = 3;
    localparam int NUM_REG   = 1 << REG_SIZE;

    localparam logic [UNIT_SIZE-1:0] READY_TAG = 8'b01111111;

    localparam logic [2:0] UNIT_LW   = 3'b000;
    localparam logic [2:0] UNIT_SW   = 3'b001;
    localparam logic [2:0] UNIT_ADD  = 3'b010;
    localparam logic [2:0] UNIT_MUL  = 3'b011;
    localparam logic [2:0] UNIT_MV   = 3'b100;
    localparam logic [2:0] UNIT_HALT = 3'b101;

    typedef struct packed {
        logic                 rdy;
        logic [UNIT_SIZE-1:0] tag;
        logic [WORD_SIZE-1:0] val;
    } opnd_t;

    // Unused operand slots: ready, value 0.
    localparam opnd_t OPND_ZERO = '{rdy: 1'b1, tag: '0, val: '0};

    // Capture a register operand: ready value, same-cycle broadcast bypass,
    // or wait on the producer tag.
    function automatic opnd_t capture(input logic [UNIT_SIZE-1:0] rtag,
                                      input logic [WORD_SIZE-1:0] rval,
                                      input logic                 hit,
                                      input logic [UNIT_SIZE-1:0] ctag,
                                      input logic [WORD_SIZE-1:0] cval);
        opnd_t o;
        if (rtag == READY_TAG) begin
            o = '{rdy: 1'b1, tag: '0, val: rval};
        end else if (hit && (rtag == ctag)) begin
            o = '{rdy: 1'b1, tag: '0, val: cval};
        end else begin
            o = '{rdy: 1'b0, tag: rtag, val: '0};
        end
        return o;
    endfunction

    function automatic opnd_t imm_opnd(input logic [WORD_SIZE-1:0] v);
        return '{rdy: 1'b1, tag: '0, val: v};
    endfunction

endpackage

// File: rtl/rs_dispatch_select.sv
// rs_select: lowest-index priority picker.
//   mask  in  NUM_ENT   candidate bits
//   idx   out ENT_IDX_W index of lowest set bit (0 when none)
//   found out 1         any bit set
module rs_select
    import rs_dispatch_pkg::*;
(
    input  logic [NUM_ENT-1:0]   mask,
    output logic [ENT_IDX_W-1:0] idx,
    output logic                 found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = ENT_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_dispatch.sv
// rs_dispatch: 8-entry reservation station with register-status table.
//   clk, rst                 clock, asynchronous active-high reset
//   unit, reg1..3, hasimm, imm   instruction being offered for dispatch
//   enable / out             dispatch request / accept (commits on edge)
//   regread, regin           status read port -> regout (tag), regoutrf (value)
//   cdb_valid/tag/value      result broadcast; frees entry cdb_tag
//   iss_*                    issue port for the lowest ready entry
//   halted                   halt dispatched and all entries drained
module rs_dispatch
    import rs_dispatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           unit,
    input  logic [REG_SIZE-1:0]  reg1,
    input  logic [REG_SIZE-1:0]  reg2,
    input  logic [REG_SIZE-1:0]  reg3,
    input  logic                 hasimm,
    input  logic [WORD_SIZE-1:0] imm,
    input  logic                 enable,
    output logic                 out,
    input  logic                 regread,
    input  logic [REG_SIZE-1:0]  regin,
    output logic [UNIT_SIZE-1:0] regout,
    output logic [WORD_SIZE-1:0] regoutrf,
    input  logic                 cdb_valid,
    input  logic [UNIT_SIZE-1:0] cdb_tag,
    input  logic [WORD_SIZE-1:0] cdb_value,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [2:0]           iss_unit,
    output logic [UNIT_SIZE-1:0] iss_tag,
    output logic [WORD_SIZE-1:0] iss_va,
    output logic [WORD_SIZE-1:0] iss_vb,
    output logic [WORD_SIZE-1:0] iss_vc,
    output logic                 halted
);

    logic [NUM_ENT-1:0]   ent_valid;
    logic [NUM_ENT-1:0]   ent_issued;
    logic [2:0]           ent_unit [NUM_ENT];
    opnd_t                ent_op   [NUM_ENT][3];
    logic [UNIT_SIZE-1:0] reg_tag  [NUM_REG];
    logic [WORD_SIZE-1:0] reg_val  [NUM_REG];
    logic                 halt_pending;

    logic [NUM_ENT-1:0]   free_mask, rdy_mask;
    logic [ENT_IDX_W-1:0] alloc_idx, iss_idx;
    logic                 alloc_found, iss_found;
    logic                 cdb_hit, is_halt, dispatch, has_dest;
    opnd_t                new_op [3];

    // Broadcasts for out-of-range tags or free entries are ignored.
    assign cdb_hit = cdb_valid && (cdb_tag[UNIT_SIZE-1:ENT_IDX_W] == '0)
                     && ent_valid[cdb_tag[ENT_IDX_W-1:0]];

    assign free_mask = ~ent_valid;
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            rdy_mask[i] = ent_valid[i] && !ent_issued[i]
                          && ent_op[i][0].rdy && ent_op[i][1].rdy && ent_op[i][2].rdy;
        end
    end

    rs_select u_alloc (
        .mask  (free_mask),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    rs_select u_issue (
        .mask  (rdy_mask),
        .idx   (iss_idx),
        .found (iss_found)
    );

    always_comb begin
        is_halt   = (unit == UNIT_HALT);
        out       = !rst && enable && !halt_pending && (alloc_found || is_halt);
        dispatch  = out && !is_halt;
        has_dest  = 1'b0;
        new_op[0] = OPND_ZERO;
        new_op[1] = OPND_ZERO;
        new_op[2] = OPND_ZERO;
        case (unit)
            UNIT_LW, UNIT_ADD, UNIT_MUL: begin
                has_dest  = 1'b1;
                new_op[0] = capture(reg_tag[reg2], reg_val[reg2], cdb_hit, cdb_tag, cdb_value);
                new_op[1] = hasimm ? imm_opnd(imm)
                          : capture(reg_tag[reg3], reg_val[reg3], cdb_hit, cdb_tag, cdb_value);
            end
            UNIT_SW: begin
                new_op[0] = capture(reg_tag[reg2], reg_val[reg2], cdb_hit, cdb_tag, cdb_value);
                new_op[1] = hasimm ? imm_opnd(imm)
                          : capture(reg_tag[reg3], reg_val[reg3], cdb_hit, cdb_tag, cdb_value);
                new_op[2] = capture(reg_tag[reg1], reg_val[reg1], cdb_hit, cdb_tag, cdb_value);
            end
            UNIT_MV: begin
                has_dest  = 1'b1;
                new_op[0] = hasimm ? imm_opnd(imm)
                          : capture(reg_tag[reg2], reg_val[reg2], cdb_hit, cdb_tag, cdb_value);
            end
            default: ;
        endcase
    end

    assign iss_valid = iss_found;
    assign iss_unit  = ent_unit[iss_idx];
    assign iss_tag   = UNIT_SIZE'(iss_idx);
    assign iss_va    = ent_op[iss_idx][0].val;
    assign iss_vb    = ent_op[iss_idx][1].val;
    assign iss_vc    = ent_op[iss_idx][2].val;
    assign halted    = halt_pending && (ent_valid == '0);

    assign regout   = (regread && !rst) ? reg_tag[regin] : '0;
    assign regoutrf = (regread && !rst) ? reg_val[regin] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid    <= '0;
            ent_issued   <= '0;
            halt_pending <= 1'b0;
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_unit[i] <= '0;
                for (int j = 0; j < 3; j++) ent_op[i][j] <= OPND_ZERO;
            end
            for (int r = 0; r < NUM_REG; r++) begin
                reg_tag[r] <= READY_TAG;
                reg_val[r] <= '0;
            end
        end else begin
            if (iss_found && iss_ready) ent_issued[iss_idx] <= 1'b1;
            if (cdb_hit) begin
                ent_valid[cdb_tag[ENT_IDX_W-1:0]] <= 1'b0;
                for (int i = 0; i < NUM_ENT; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (ent_valid[i] && !ent_op[i][j].rdy && ent_op[i][j].tag == cdb_tag) begin
                            ent_op[i][j].rdy <= 1'b1;
                            ent_op[i][j].val <= cdb_value;
                        end
                    end
                end
                for (int r = 0; r < NUM_REG; r++) begin
                    // A same-cycle dispatch renaming this register keeps its new tag.
                    if (reg_tag[r] == cdb_tag
                        && !(dispatch && has_dest && reg1 == REG_SIZE'(r))) begin
                        reg_tag[r] <= READY_TAG;
                        reg_val[r] <= cdb_value;
                    end
                end
            end
            if (dispatch) begin
                ent_valid[alloc_idx]  <= 1'b1;
                ent_issued[alloc_idx] <= 1'b0;
                ent_unit[alloc_idx]   <= unit;
                for (int j = 0; j < 3; j++) ent_op[alloc_idx][j] <= new_op[j];
                if (has_dest) reg_tag[reg1] <= UNIT_SIZE'(alloc_idx);
            end
            if (out && is_halt) halt_pending <= 1'b1;
        end
    end

endmodule
